// File: rtl/mcpu_pkg.sv
// Shared definitions for the MCPU memory arbiter: FSM state encoding,
// requester port identifiers and default bus widths.
package mcpu_pkg;

  localparam int MCPU_WORD_SIZE  = 16;
  localparam int MCPU_ADDR_WIDTH = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RDATA  = 2'b10
  } arb_state_e;

endpackage

// File: rtl/mcpu_rr_arb2.sv
// Two-way request picker: round-robin on last_gnt by default, or CPU-first
// fixed priority when MCPU_ARB_FIXED_PRIO_EN is defined.
module mcpu_rr_arb2
  import mcpu_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic winner,
  output logic valid
);

  assign valid = req0 | req1;

`ifdef MCPU_ARB_FIXED_PRIO_EN
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
  assign winner = req0 ? PORT_CPU : PORT_DMA;
`else
  always_comb begin
    winner = PORT_CPU;
    if (req0 && req1) begin
      winner = ~last_gnt;
    end else if (req1) begin
      winner = PORT_DMA;
    end
  end
`endif

endmodule

// File: rtl/mcpu_mem_arbiter.sv
// Shares the MCPU RAM data port between the CPU (port 0) and a DMA master
// (port 1), one transaction in flight. Macro MCPU_ARB_FIXED_PRIO_EN selects CPU priority.
module mcpu_mem_arbiter
  import mcpu_pkg::*;
#(
  parameter int WORD_SIZE  = MCPU_WORD_SIZE,
  parameter int ADDR_WIDTH = MCPU_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [WORD_SIZE-1:0]  wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [WORD_SIZE-1:0]  rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [WORD_SIZE-1:0]  wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [WORD_SIZE-1:0]  rdata1,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WORD_SIZE-1:0]  ram_wdata,
  input  logic [WORD_SIZE-1:0]  ram_rdata
);

  arb_state_e            state_reg, state_next;
  logic                  last_gnt_reg;
  logic                  cmd_owner_reg;
  logic                  cmd_we_reg;
  logic [ADDR_WIDTH-1:0] cmd_addr_reg;
  logic [WORD_SIZE-1:0]  cmd_wdata_reg;
  logic                  rvalid_reg [2];
  logic [WORD_SIZE-1:0]  rdata_reg  [2];

  logic pick_winner;
  logic pick_valid;
  logic grant_en;
  logic capture;

  mcpu_rr_arb2 u_pick (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt_reg),
    .winner   (pick_winner),
    .valid    (pick_valid)
  );

  // grant_en is gated by reset so no grant escapes during a reset cycle
  always_comb begin
    state_next = state_reg;
    grant_en   = 1'b0;
    capture    = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_valid && !reset) begin
          grant_en   = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        ram_we     = cmd_we_reg;
        ram_re     = !cmd_we_reg;
        state_next = cmd_we_reg ? IDLE : RDATA;
      end
      RDATA: begin
        capture    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      last_gnt_reg  <= PORT_DMA;
      cmd_owner_reg <= PORT_CPU;
      cmd_we_reg    <= 1'b0;
      cmd_addr_reg  <= '0;
      cmd_wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_en) begin
        last_gnt_reg  <= pick_winner;
        cmd_owner_reg <= pick_winner;
        cmd_we_reg    <= (pick_winner == PORT_DMA) ? we1    : we0;
        cmd_addr_reg  <= (pick_winner == PORT_DMA) ? addr1  : addr0;
        cmd_wdata_reg <= (pick_winner == PORT_DMA) ? wdata1 : wdata0;
      end
    end
  end

  // Read return: only the owner's data register is touched
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    localparam logic PORT_ID = (gi == 1);
    always_ff @(posedge clk) begin
      if (reset) begin
        rvalid_reg[gi] <= 1'b0;
        rdata_reg[gi]  <= '0;
      end else begin
        rvalid_reg[gi] <= capture && (cmd_owner_reg == PORT_ID);
        if (capture && (cmd_owner_reg == PORT_ID)) begin
          rdata_reg[gi] <= ram_rdata;
        end
      end
    end
  end

  assign gnt0      = grant_en && (pick_winner == PORT_CPU);
  assign gnt1      = grant_en && (pick_winner == PORT_DMA);
  assign rvalid0   = rvalid_reg[0];
  assign rvalid1   = rvalid_reg[1];
  assign rdata0    = rdata_reg[0];
  assign rdata1    = rdata_reg[1];
  assign ram_addr  = cmd_addr_reg;
  assign ram_wdata = cmd_wdata_reg;

endmodule

// File: tb/tb_mcpu_mem_arbiter.sv
// Scoreboard bench for mcpu_mem_arbiter: a transaction-level model predicts
// grants, RAM strobes and read returns; a monitor compares them every cycle.
module tb_mcpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a   [2];
  logic        we_a    [2];
  logic [7:0]  addr_a  [2];
  logic [15:0] wdata_a [2];
  logic        gnt_a   [2];
  logic        rvalid_a[2];
  logic [15:0] rdata_a [2];
  logic        ram_we, ram_re;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = 16'h0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    bit          we;
    logic [7:0]  addr;
    logic [15:0] data;
  } ev_t;

  ev_t         ramq [$];
  ev_t         rvq0 [$];
  ev_t         rvq1 [$];
  logic [15:0] env_mem [256];
  logic [15:0] ref_mem [256];
  logic [15:0] exp_rdata [2];
  bit          last_m;
  int          free_cyc;
  bit          prev_gnt [2];

  mcpu_mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req_a[0]),
    .we0       (we_a[0]),
    .addr0     (addr_a[0]),
    .wdata0    (wdata_a[0]),
    .gnt0      (gnt_a[0]),
    .rvalid0   (rvalid_a[0]),
    .rdata0    (rdata_a[0]),
    .req1      (req_a[1]),
    .we1       (we_a[1]),
    .addr1     (addr_a[1]),
    .wdata1    (wdata_a[1]),
    .gnt1      (gnt_a[1]),
    .rvalid1   (rvalid_a[1]),
    .rdata1    (rdata_a[1]),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM environment: registered read, data valid the cycle after ram_re
  always @(posedge clk) begin
    if (ram_we) env_mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= env_mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor and reference model, sampled mid-cycle
  always @(negedge clk) begin
    bit e0, e1, w, hit;
    ev_t ev;
    if (reset) begin
      ramq.delete(); rvq0.delete(); rvq1.delete();
      last_m = 1'b1;
      free_cyc = cyc + 1;
      exp_rdata[0] = 16'h0; exp_rdata[1] = 16'h0;
      prev_gnt[0] = 1'b0; prev_gnt[1] = 1'b0;
    end else begin
      e0 = 1'b0; e1 = 1'b0; w = 1'b0;
      if (cyc >= free_cyc && (req_a[0] || req_a[1])) begin
        if (req_a[0] && req_a[1]) begin
`ifdef MCPU_ARB_FIXED_PRIO_EN
          w = 1'b0;
`else
          w = !last_m;
`endif
        end else begin
          w = req_a[1];
        end
        e0 = !w; e1 = w;
      end
      chk("gnt0", gnt_a[0], e0);
      chk("gnt1", gnt_a[1], e1);
      chk("gnt_exclusive", gnt_a[0] & gnt_a[1], 0);
      chk("gnt0_pulse", gnt_a[0] & prev_gnt[0], 0);
      chk("gnt1_pulse", gnt_a[1] & prev_gnt[1], 0);
      chk("ram_we_re_exclusive", ram_we & ram_re, 0);
      prev_gnt[0] = gnt_a[0]; prev_gnt[1] = gnt_a[1];

      hit = (ramq.size() > 0) && (ramq[0].cyc == cyc);
      if (hit) begin
        ev = ramq.pop_front();
        chk("ram_we", ram_we, ev.we);
        chk("ram_re", ram_re, !ev.we);
        chk("ram_addr", ram_addr, ev.addr);
        if (ev.we) chk("ram_wdata", ram_wdata, ev.data);
      end else begin
        chk("ram_strobe_idle", {ram_we, ram_re}, 0);
      end

      hit = (rvq0.size() > 0) && (rvq0[0].cyc == cyc);
      chk("rvalid0", rvalid_a[0], hit);
      if (hit) begin
        ev = rvq0.pop_front();
        exp_rdata[0] = ev.data;
      end
      hit = (rvq1.size() > 0) && (rvq1[0].cyc == cyc);
      chk("rvalid1", rvalid_a[1], hit);
      if (hit) begin
        ev = rvq1.pop_front();
        exp_rdata[1] = ev.data;
      end
      chk("rdata0", rdata_a[0], exp_rdata[0]);
      chk("rdata1", rdata_a[1], exp_rdata[1]);

      if (e0 || e1) begin
        ev = '{cyc + 1, we_a[w], addr_a[w], wdata_a[w]};
        ramq.push_back(ev);
        $display("grant port %0d %s addr %h wdata %h cycle %0d",
                 w, we_a[w] ? "WR" : "RD", addr_a[w], wdata_a[w], cyc);
        if (we_a[w]) begin
          ref_mem[addr_a[w]] = wdata_a[w];
          free_cyc = cyc + 2;
        end else begin
          ev = '{cyc + 3, 1'b0, addr_a[w], ref_mem[addr_a[w]]};
          if (w) rvq1.push_back(ev); else rvq0.push_back(ev);
          free_cyc = cyc + 3;
        end
        last_m = w;
      end
    end
  end

  // Present one command and hold it until granted; returns in the cycle after gnt
  task automatic drive(input int p, input bit w, input logic [7:0] a, input logic [15:0] d);
    int n;
    req_a[p] = 1'b1; we_a[p] = w; addr_a[p] = a; wdata_a[p] = d;
    n = 0;
    @(negedge clk);
    while (!gnt_a[p] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("gnt_timeout", (n < 300), 1);
    @(posedge clk); #1;
    req_a[p] = 1'b0;
  endtask

  task automatic run_port(input int p, input int count, input bit rnd);
    for (int i = 0; i < count; i++) begin
      if (rnd) begin
        drive(p, 1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 7)),
              16'($urandom));
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end else begin
        drive(p, 1'b0, 8'h20 + 8'(i), 16'($urandom));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 16'(i * 257 + 3);
      ref_mem[i] = 16'(i * 257 + 3);
    end
    env_mem[8'h20] = 16'h1234;
    ref_mem[8'h20] = 16'h1234;
    for (int p = 0; p < 2; p++) begin
      req_a[p] = 1'b0; we_a[p] = 1'b0; addr_a[p] = 8'h0; wdata_a[p] = 16'h0;
    end

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_ram_addr", ram_addr, 0);
    chk("reset_ram_wdata", ram_wdata, 0);

    // Directed write, then read of preloaded word by DMA
    @(posedge clk); #1;
    drive(0, 1'b1, 8'h10, 16'hBEEF);
    repeat (3) @(posedge clk); #1;
    drive(1, 1'b0, 8'h20, 16'h0);
    repeat (4) @(posedge clk); #1;
    chk("read_result", rdata_a[1], 16'h1234);

    // Continuous contention with reads
    fork
      run_port(0, 6, 1'b0);
      run_port(1, 6, 1'b0);
    join
    repeat (4) @(posedge clk); #1;

    // Lone requester, back-to-back writes
    for (int i = 0; i < 4; i++) drive(0, 1'b1, 8'(i), 16'($urandom));
    repeat (4) @(posedge clk); #1;

    // Reset during the ACCESS cycle of a DMA read
    drive(1, 1'b0, 8'h20, 16'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ram_addr", ram_addr, 0);
    chk("abort_ram_wdata", ram_wdata, 0);
    chk("abort_rdata1", rdata_a[1], 0);
    @(posedge clk); #1;
    fork
      drive(0, 1'b0, 8'h03, 16'h0);
      drive(1, 1'b0, 8'h10, 16'h0);
    join
    repeat (4) @(posedge clk); #1;

    // Randomised mixed traffic from both ports
    fork
      run_port(0, 40, 1'b1);
      run_port(1, 40, 1'b1);
    join
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("ramq_drained", ramq.size(), 0);
    chk("rvq0_drained", rvq0.size(), 0);
    chk("rvq1_drained", rvq1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
